// File: rtl/console_pkg.sv
// Shared definitions for the console front-panel input conditioning blocks.
package console_pkg;

   // Debouncer state encoding; bit 0 tracks the value being qualified or held,
   // and the two WAIT states differ from their IDLE partner in one bit.
   typedef enum logic [1:0] {
      IDLE_LOW  = 2'b00,
      WAIT_HIGH = 2'b01,
      IDLE_HIGH = 2'b11,
      WAIT_LOW  = 2'b10
   } deb_state_t;

   // 1 ms of stability at a 50 MHz system clock.
   localparam int unsigned DEFAULT_STABLE_COUNT = 50000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button line in, conditioned level and edge pulses out.
// master drives the raw line; slave is the debouncer.
interface button_debouncer_if;
   logic btn_raw;
   logic level;
   logic rise_pulse;
   logic fall_pulse;
   logic busy;

   modport master (output btn_raw, input level, rise_pulse, fall_pulse, busy);
   modport slave  (input btn_raw, output level, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous console input.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1;

   // Shift the asynchronous input through two flops; both clear on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one front-panel button/switch line: synchronizer, stability
// counter and a four-state FSM producing a clean level plus edge pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_LOW  | level = 0, waiting for the synchronized input to go high
// WAIT_HIGH | input seen high, counting stable cycles before accepting
// IDLE_HIGH | level = 1, waiting for the synchronized input to go low
// WAIT_LOW  | input seen low, counting stable cycles before accepting
module button_debouncer
   import console_pkg::*;
#(
   parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter bit          ACTIVE_LOW   = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   button_debouncer_if.slave   btn
);

   if (STABLE_COUNT < 1 || (64'd1 << CNT_WIDTH) < 64'(STABLE_COUNT)) begin : g_param_check
      $error("button_debouncer: STABLE_COUNT must be >= 1 and fit in CNT_WIDTH bits");
   end

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   deb_state_t           state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 s2;
   logic                 level_q;
   logic                 rise_q;
   logic                 fall_q;

   // Polarity is normalised before the synchronizer so reset means "released".
   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn.btn_raw ^ ACTIVE_LOW),
      .q     (s2)
   );

   // Qualify candidate changes on s2; pulses default low every cycle so they
   // can only ever be one cycle wide.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE_LOW;
         cnt     <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s2) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!s2) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE_HIGH;
                  cnt     <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            IDLE_HIGH: begin
               if (!s2) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
               end
            end
            WAIT_LOW: begin
               if (s2) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= IDLE_LOW;
                  cnt     <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign btn.level      = level_q;
   assign btn.rise_pulse = rise_q;
   assign btn.fall_pulse = fall_q;
   assign btn.busy       = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_COUNT=4; a second instance
// exercises ACTIVE_LOW=1.
module tb_button_debouncer;
   import console_pkg::*;

   localparam int SC = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   button_debouncer_if dif ();
   button_debouncer_if dif_n ();

   button_debouncer #(.STABLE_COUNT(SC), .CNT_WIDTH(16), .ACTIVE_LOW(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (dif.slave)
   );

   button_debouncer #(.STABLE_COUNT(SC), .CNT_WIDTH(16), .ACTIVE_LOW(1'b1)) dut_n (
      .clk   (clk),
      .reset (reset),
      .btn   (dif_n.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dif.btn_raw = 1'b0;
      dif_n.btn_raw = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000",
                  {dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy});
      end
      reset = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         n_tests++;
         if ({dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset e%0d: got %b expected 0000", e,
                     {dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy});
         end
      end
   endtask

   task automatic test_rise();
      logic exp_busy, exp_level, exp_rise;
      dif.btn_raw = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         exp_busy  = (e >= 2) && (e <= SC + 1);
         exp_level = (e >= SC + 2);
         exp_rise  = (e == SC + 2);
         n_tests++;
         if ({dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy} !==
             {exp_level, exp_rise, 1'b0, exp_busy}) begin
            n_fail++;
            $display("FAIL rise e%0d: got lvl/rise/fall/busy=%b expected %b", e,
                     {dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy},
                     {exp_level, exp_rise, 1'b0, exp_busy});
         end
      end
   endtask

   task automatic test_glitch();
      logic saw_busy;
      saw_busy = 1'b0;
      dif.btn_raw = 1'b0;
      for (int e = 0; e < 13; e++) begin
         tick();
         if (e == 2) dif.btn_raw = 1'b1;
         saw_busy |= dif.busy;
         n_tests++;
         if (dif.level !== 1'b1 || dif.fall_pulse !== 1'b0 || dif.rise_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_hold e%0d: got lvl=%b fall=%b rise=%b expected lvl=1 fall=0 rise=0",
                     e, dif.level, dif.fall_pulse, dif.rise_pulse);
         end
      end
      n_tests++;
      if (saw_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_busy_seen: got %b expected 1", saw_busy);
      end
      n_tests++;
      if (dif.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy_end: got %b expected 0", dif.busy);
      end
   endtask

   task automatic test_bounce();
      logic vals [6];
      int   n_rise;
      int   rise_edge;
      vals = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      n_rise = 0;
      rise_edge = -1;
      dif.btn_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      n_tests++;
      if (dif.level !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_setup_level: got %b expected 0", dif.level);
      end
      // The final 0->1 is applied before edge 5, so acceptance lands on edge 11.
      for (int e = 0; e < 16; e++) begin
         dif.btn_raw = (e < 6) ? vals[e] : 1'b1;
         tick();
         if (dif.rise_pulse === 1'b1) begin
            n_rise++;
            rise_edge = e;
         end
         n_tests++;
         if (dif.fall_pulse !== 1'b0 || (e < 11 && dif.level !== 1'b0)) begin
            n_fail++;
            $display("FAIL bounce_quiet e%0d: got lvl=%b fall=%b expected fall=0, lvl=0 before e11",
                     e, dif.level, dif.fall_pulse);
         end
      end
      n_tests++;
      if (n_rise !== 1 || rise_edge !== 11) begin
         n_fail++;
         $display("FAIL bounce_rise: got %0d pulses at edge %0d expected 1 pulse at edge 11",
                  n_rise, rise_edge);
      end
   endtask

   task automatic test_reset_mid();
      int n_rise;
      int rise_edge;
      n_rise = 0;
      rise_edge = -1;
      dif.btn_raw = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      dif.btn_raw = 1'b1;
      for (int e = 0; e < 5; e++) tick();
      n_tests++;
      if (dif.busy !== 1'b1 || dif.level !== 1'b0) begin
         n_fail++;
         $display("FAIL midwait_before_reset: got busy=%b lvl=%b expected busy=1 lvl=0",
                  dif.busy, dif.level);
      end
      reset = 1'b1;
      tick();
      n_tests++;
      if ({dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midwait_reset: got %b expected 0000",
                  {dif.level, dif.rise_pulse, dif.fall_pulse, dif.busy});
      end
      reset = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (dif.rise_pulse === 1'b1) begin
            n_rise++;
            rise_edge = e;
         end
      end
      n_tests++;
      if (n_rise !== 1 || rise_edge !== SC + 2 || dif.level !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_exit_rise: got %0d pulses at edge %0d lvl=%b expected 1 pulse at edge %0d lvl=1",
                  n_rise, rise_edge, dif.level, SC + 2);
      end
   endtask

   task automatic test_active_low();
      logic exp_level, exp_pulse;
      reset = 1'b1;
      dif_n.btn_raw = 1'b0;
      tick();
      tick();
      n_tests++;
      if (dif_n.level !== 1'b0 || dif_n.rise_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL al_reset: got lvl=%b rise=%b expected 0 0", dif_n.level, dif_n.rise_pulse);
      end
      reset = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_level = (e >= SC + 2);
         exp_pulse = (e == SC + 2);
         n_tests++;
         if (dif_n.level !== exp_level || dif_n.rise_pulse !== exp_pulse || dif_n.fall_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL al_press e%0d: got lvl=%b rise=%b fall=%b expected lvl=%b rise=%b fall=0",
                     e, dif_n.level, dif_n.rise_pulse, dif_n.fall_pulse, exp_level, exp_pulse);
         end
      end
      dif_n.btn_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         exp_level = (e < SC + 2);
         exp_pulse = (e == SC + 2);
         n_tests++;
         if (dif_n.level !== exp_level || dif_n.fall_pulse !== exp_pulse || dif_n.rise_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL al_release e%0d: got lvl=%b fall=%b rise=%b expected lvl=%b fall=%b rise=0",
                     e, dif_n.level, dif_n.fall_pulse, dif_n.rise_pulse, exp_level, exp_pulse);
         end
      end
   endtask

   initial begin
      dif.btn_raw = 1'b0;
      dif_n.btn_raw = 1'b1;
      test_reset();
      test_rise();
      test_glitch();
      test_bounce();
      test_reset_mid();
      test_active_low();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
